pixel_depth_writer: RTL

PIXEL_DEPTH_WRITER -- requirements
Module: pixel_depth_writer

---
 rtl/pixel_depth_writer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pixel_depth_writer.sv
// Depth-tested pixel writer with a one-cycle read/compare/write pipeline
// and a sequenced framebuffer/depth clear.
module pixel_depth_writer #(
  parameter int unsigned FB_WIDTH    = 160,
  parameter int unsigned FB_HEIGHT   = 120,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic [15:0] pixel_x,
  input  logic [15:0] pixel_y,
  input  logic [11:0] pixel_color,
  input  logic [31:0] pixel_depth,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        clear_done,
  output logic        z_rd_en,
  output logic [14:0] z_rd_addr,
  input  logic [31:0] z_rd_data,
  output logic        z_wr_en,
  output logic [14:0] z_wr_addr,
  output logic [31:0] z_wr_data,
  output logic        fb_wr_en,
  output logic [14:0] fb_wr_addr,
  output logic [11:0] fb_wr_data,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count,
  output logic [15:0] clip_count
);

  // state    | meaning
  // ST_IDLE  | accepting pixels, sampling clear_start
  // ST_FLUSH | last accepted pixel completes; counters zeroed
  // ST_CLEAR | one clear write per cycle over the whole buffer
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_FLUSH = 2'd1;
  localparam logic [1:0]  ST_CLEAR = 2'd2;
  localparam logic [14:0] LAST_ADDR = 15'(FB_WIDTH * FB_HEIGHT - 1);
  localparam logic [31:0] Z_FAR     = 32'h7FFF_FFFF;

  logic [1:0]  state_q, state_d;
  logic [14:0] clear_addr_q, clear_addr_d;
  logic        clear_done_q, clear_done_d;
  logic        r_valid_q;
  logic [14:0] r_addr_q;
  logic [11:0] r_color_q;
  logic [31:0] r_depth_q;
  logic        fwd_valid_q;
  logic [14:0] fwd_addr_q;
  logic [31:0] fwd_data_q;
  logic [15:0] pass_q, pass_d, fail_q, fail_d, clip_q, clip_d;

  logic        accept, in_bounds, depth_pass;
  logic [31:0] lin_addr;
  logic [31:0] stored_depth;

  assign pixel_ready = (state_q == ST_IDLE) && rst_n;
  assign accept      = pixel_valid && pixel_ready;
  assign in_bounds   = (32'(pixel_x) < FB_WIDTH) && (32'(pixel_y) < FB_HEIGHT);
  assign lin_addr    = 32'(pixel_y) * FB_WIDTH + 32'(pixel_x);
  assign z_rd_en     = accept && in_bounds;
  assign z_rd_addr   = lin_addr[14:0];

  // Read-first memory misses last cycle's write; the forward register covers it.
  assign stored_depth = (fwd_valid_q && (fwd_addr_q == r_addr_q)) ? fwd_data_q : z_rd_data;
  assign depth_pass   = $signed(r_depth_q) < $signed(stored_depth);

  assign clear_busy = (state_q != ST_IDLE);
  assign clear_done = clear_done_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign clip_count = clip_q;

  always_comb begin
    z_wr_en    = 1'b0;
    z_wr_addr  = r_addr_q;
    z_wr_data  = r_depth_q;
    fb_wr_en   = 1'b0;
    fb_wr_addr = r_addr_q;
    fb_wr_data = r_color_q;
    if (state_q == ST_CLEAR) begin
      z_wr_en    = 1'b1;
      z_wr_addr  = clear_addr_q;
      z_wr_data  = Z_FAR;
      fb_wr_en   = 1'b1;
      fb_wr_addr = clear_addr_q;
      fb_wr_data = CLEAR_COLOR;
    end else if (r_valid_q && depth_pass) begin
      z_wr_en  = 1'b1;
      fb_wr_en = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    clear_done_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (clear_start) state_d = ST_FLUSH;
      ST_FLUSH: begin
        state_d      = ST_CLEAR;
        clear_addr_d = '0;
      end
      ST_CLEAR: begin
        if (clear_addr_q == LAST_ADDR) begin
          state_d      = ST_IDLE;
          clear_done_d = 1'b1;
          clear_addr_d = '0;
        end else begin
          clear_addr_d = clear_addr_q + 15'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    clip_d = clip_q;
    if (r_valid_q && depth_pass)  pass_d = pass_q + 16'd1;
    if (r_valid_q && !depth_pass) fail_d = fail_q + 16'd1;
    if (accept && !in_bounds)     clip_d = clip_q + 16'd1;
    // Zeroing wins over the flushed pixel's own statistic.
    if (state_q == ST_FLUSH) begin
      pass_d = '0;
      fail_d = '0;
      clip_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clear_addr_q <= '0;
      clear_done_q <= 1'b0;
      r_valid_q    <= 1'b0;
      r_addr_q     <= '0;
      r_color_q    <= '0;
      r_depth_q    <= '0;
      fwd_valid_q  <= 1'b0;
      fwd_addr_q   <= '0;
      fwd_data_q   <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      clip_q       <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      clear_done_q <= clear_done_d;
      r_valid_q    <= accept && in_bounds;
      r_addr_q     <= lin_addr[14:0];
      r_color_q    <= pixel_color;
      r_depth_q    <= pixel_depth;
      fwd_valid_q  <= z_wr_en;
      fwd_addr_q   <= z_wr_addr;
      fwd_data_q   <= z_wr_data;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      clip_q       <= clip_d;
    end
  end

endmodule
